// File: rtl/lfsr_rand_server_pkg.sv
// Shared LFSR constants, FSM state type and next-state helpers for lfsr_rand_server.
package lfsr_rand_server_pkg;

    localparam int LFSR_W = 15;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 15'h7FFF;

    typedef enum logic [2:0] {
        WARM,
        IDLE,
        STEP,
        REDUCE,
        DONE
    } state_t;

    // XNOR feedback from the two top taps; all-ones is the only state it cannot leave.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ~(v[LFSR_W-1] ^ v[LFSR_W-2])};
    endfunction

    function automatic logic [LFSR_W-1:0] lockup_map(input logic [LFSR_W-1:0] s);
        return (s == LFSR_LOCKUP) ? '0 : s;
    endfunction

endpackage

// File: rtl/lfsr_rand_server_lfsr15_core.sv
// 15-bit XNOR LFSR register with seed load (lockup seed mapped to zero).
// Latency: one cycle per step or load; no backpressure, steps whenever step is high.
module lfsr15_core
    import lfsr_rand_server_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= lockup_map(seed);
        end else if (step) begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/lfsr_rand_server.sv
// Round-robin server handing out LFSR-derived indices in [0, MODULUS) to NREQ requesters.
// Latency: req sampled in IDLE -> gnt/rand_valid pulse 17 cycles later; one result per 18 cycles.
// Backpressure: none; req is a held level, results are one-cycle pulses with rand_out held.
module lfsr_rand_server
    import lfsr_rand_server_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MODULUS = 25,
    parameter int OUT_W   = 5,
    parameter int WARMUP  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [NREQ-1:0]   gnt,
    output logic              rand_valid,
    output logic [OUT_W-1:0]  rand_out,
    output logic              busy
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCNT_W = $clog2(WARMUP + 1);
    localparam logic [OUT_W:0]      MOD_V     = (OUT_W + 1)'(MODULUS);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NREQ - 1);
    localparam logic [WCNT_W-1:0]   WARM_LAST = WCNT_W'(WARMUP - 1);
    localparam logic [3:0]          TOP_BIT   = 4'(LFSR_W - 1);

    state_t              state;
    logic [WCNT_W-1:0]   warm_cnt;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    arb_idx;
    logic [IDX_W-1:0]    hi_idx;
    logic [IDX_W-1:0]    lo_idx;
    logic                hi_found;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [LFSR_W-1:0]   dividend;
    logic [3:0]          bit_cnt;
    logic [OUT_W:0]      rem_q;
    logic [OUT_W:0]      rem_shift;
    logic [OUT_W:0]      rem_next;
    logic                lfsr_step;
    logic                lfsr_load;

    assign busy      = (state != IDLE);
    assign lfsr_step = (state == WARM) || (state == STEP);
    assign lfsr_load = (state == IDLE) && seed_load;

    lfsr15_core u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .load  (lfsr_load),
        .seed  (seed),
        .out   (lfsr_q)
    );

    // Lowest set bit above last_grant wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        arb_idx = hi_found ? hi_idx : lo_idx;
    end

    // Restoring remainder step: the remainder stays below MODULUS, so one subtract suffices.
    assign rem_shift = (rem_q << 1) | (OUT_W + 1)'(dividend[bit_cnt]);
    assign rem_next  = (rem_shift >= MOD_V) ? (rem_shift - MOD_V) : rem_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WARM;
            warm_cnt   <= '0;
            last_grant <= LAST_IDX;
            sel_idx    <= '0;
            dividend   <= '0;
            bit_cnt    <= '0;
            rem_q      <= '0;
            gnt        <= '0;
            rand_valid <= 1'b0;
            rand_out   <= '0;
        end else begin
            gnt        <= '0;
            rand_valid <= 1'b0;
            case (state)
                WARM: begin
                    if (warm_cnt == WARM_LAST) begin
                        state <= IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (seed_load) begin
                        warm_cnt <= '0;
                        state    <= WARM;
                    end else if (|req) begin
                        sel_idx <= arb_idx;
                        state   <= STEP;
                    end
                end
                STEP: begin
                    // Same value the LFSR core takes on this edge.
                    dividend <= lfsr_next(lfsr_q);
                    rem_q    <= '0;
                    bit_cnt  <= TOP_BIT;
                    state    <= REDUCE;
                end
                REDUCE: begin
                    rem_q   <= rem_next;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == 4'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rand_out     <= rem_q[OUT_W-1:0];
                    rand_valid   <= 1'b1;
                    gnt[sel_idx] <= 1'b1;
                    last_grant   <= sel_idx;
                    state        <= IDLE;
                end
                default: state <= WARM;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Bench for lfsr_rand_server: transaction-level model plus directed literal checks.
module tb_lfsr_rand_server;

    localparam int NREQ    = 4;
    localparam int MODULUS = 25;
    localparam int OUT_W   = 5;
    localparam int WARMUP  = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic             seed_load = 1'b0;
    logic [14:0]      seed = '0;
    logic [NREQ-1:0]  gnt;
    logic             rand_valid;
    logic [OUT_W-1:0] rand_out;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic [14:0] warm_tab [16] = '{15'h0001, 15'h0003, 15'h0007, 15'h000F,
                                   15'h001F, 15'h003F, 15'h007F, 15'h00FF,
                                   15'h01FF, 15'h03FF, 15'h07FF, 15'h0FFF,
                                   15'h1FFF, 15'h3FFF, 15'h7FFE, 15'h7FFD};
    logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [4:0] rr_val [5] = '{5'd13, 5'd9, 5'd1, 5'd10, 5'd3};

    always #5 clk = ~clk;

    lfsr_rand_server #(
        .NREQ    (NREQ),
        .MODULUS (MODULUS),
        .OUT_W   (OUT_W),
        .WARMUP  (WARMUP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .seed_load  (seed_load),
        .seed       (seed),
        .gnt        (gnt),
        .rand_valid (rand_valid),
        .rand_out   (rand_out),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lstep(input int v);
        return ((v << 1) & 32'h7FFE) | ((~((v >> 14) ^ (v >> 13))) & 1);
    endfunction

    // Model: warm-up steps left, cycles left in the current service, pending result.
    int         m_lfsr  = 0;
    int         m_warm  = WARMUP;
    int         m_timer = 0;
    int         m_last  = NREQ - 1;
    int         m_sel   = 0;
    int         m_val   = 0;
    int         m_out   = 0;
    bit         m_pulse = 1'b0;
    logic [3:0] m_req   = '0;
    int         waitc [NREQ];

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_lfsr = 0; m_warm = WARMUP; m_timer = 0; m_last = NREQ - 1;
            m_sel = 0; m_val = 0; m_out = 0; m_pulse = 1'b0; m_req = '0;
            for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        end else begin
            bit found;
            m_req   = req;
            m_pulse = 1'b0;
            if (m_warm > 0) begin
                m_lfsr = lstep(m_lfsr);
                m_warm--;
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_pulse = 1'b1;
                    m_out   = m_val;
                    m_last  = m_sel;
                end
            end else if (seed_load) begin
                m_lfsr = (seed == 15'h7FFF) ? 0 : int'(seed);
                m_warm = WARMUP;
            end else if (req != 0) begin
                found = 1'b0;
                for (int i = 1; i <= NREQ; i++) begin
                    if (!found && req[(m_last + i) % NREQ]) begin
                        found = 1'b1;
                        m_sel = (m_last + i) % NREQ;
                    end
                end
                m_lfsr  = lstep(m_lfsr);
                m_val   = m_lfsr % MODULUS;
                m_timer = 17;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("gnt", gnt, m_pulse ? (32'd1 << m_sel) : 32'd0);
        check("rand_valid", rand_valid, m_pulse);
        check("rand_out", rand_out, m_out);
        check("busy", busy, (m_warm > 0) || (m_timer > 0));
        if (rand_valid) begin
            check("range", rand_out < MODULUS, 1);
            check("onehot", $countones(gnt), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    waitc[i] = 0;
                end else if (m_req[i]) begin
                    waitc[i]++;
                    check("starve", waitc[i] <= NREQ - 1, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_pulse(input int limit, output int n, output logic [3:0] g, output logic [4:0] v);
        n = 0; g = '0; v = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!rand_valid && n < limit);
        if (rand_valid) begin
            g = gnt;
            v = rand_out;
        end else begin
            check("pulse_timeout", rand_valid, 1);
        end
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        check("warm_end_busy", busy, 0);
        check("warm_end_cycles", n, 16);
    endtask

    initial begin
        int         n;
        int         bcnt;
        logic [3:0] g;
        logic [4:0] v;

        // Reset and warm-up sequence
        #2 reset = 1'b1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_valid", rand_valid, 0);
        check("rst_out", rand_out, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        bcnt = int'(busy);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check("warm_lfsr", dut.lfsr_q, warm_tab[i]);
            if (busy) bcnt++;
        end
        check("warm_busy_cycles", bcnt, 16);
        check("model_lfsr_after_warm", m_lfsr, 32'h7FFD);

        // Single requester, two back-to-back results
        @(negedge clk);
        req = 4'b0001;
        wait_pulse(40, n, g, v);
        check("r0_lat", n, 18);
        check("r0_gnt", g, 4'b0001);
        check("r0_val", v, 13);
        wait_pulse(40, n, g, v);
        check("r1_lat", n, 18);
        check("r1_gnt", g, 4'b0001);
        check("r1_val", v, 9);
        req = '0;

        // All requesters: round-robin order
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_pulse(40, n, g, v);
            check("rr_lat", n, 18);
            check("rr_gnt", g, rr_gnt[j]);
            check("rr_val", v, rr_val[j]);
        end
        req = '0;

        // Lockup seed loads as zero and replays the reset sequence
        @(negedge clk);
        seed = 15'h7FFF;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        bcnt = 0;
        while (busy && bcnt < 40) begin
            bcnt++;
            @(negedge clk);
        end
        check("seed_warm_cycles", bcnt, 16);
        req = 4'b0001;
        wait_pulse(40, n, g, v);
        check("seed_lat", n, 18);
        check("seed_val", v, 13);
        repeat (6) @(negedge clk);
        seed = 15'h1234;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        wait_pulse(40, n, g, v);
        check("ignored_seed_lat", n + 7, 18);
        check("ignored_seed_val", v, 9);
        req = '0;

        // Asynchronous reset in the middle of REDUCE
        @(negedge clk);
        req = 4'b0001;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_valid", rand_valid, 0);
        check("mid_rst_out", rand_out, 0);
        check("mid_rst_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        wait_pulse(60, n, g, v);
        check("post_rst_lat", n, 34);
        check("post_rst_gnt", g, 4'b0001);
        check("post_rst_val", v, 13);
        req = '0;

        // Random traffic; requesters hold req until granted
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                end
            end
            seed_load = ($urandom_range(0, 799) == 0);
            seed = 15'($urandom);
        end
        req = '0;
        seed_load = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
